// File: rtl/riscv_uop_pkg.sv
// Shared uop definition, RISC-V opcode constants and the functional-unit
// classification helpers used by the issue queue.
package riscv_uop_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef struct packed {
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       uses_rs1;
    logic [2:0] funct3;
  } uop_t;

  typedef enum logic {
    FU_ALU = 1'b0,
    FU_LSU = 1'b1
  } fu_sel_t;

  // Unknown opcodes fall through to the ALU so a bad uop can never wedge the head.
  function automatic fu_sel_t classify_fu(input logic [6:0] opcode);
    case (opcode)
      OPC_LOAD, OPC_STORE: return FU_LSU;
      OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
      OPC_BRANCH, OPC_JAL, OPC_JALR: return FU_ALU;
      default: return FU_ALU;
    endcase
  endfunction

  function automatic logic uop_uses_rs2(input logic [6:0] opcode);
    return (opcode == OPC_OP) || (opcode == OPC_BRANCH) || (opcode == OPC_STORE);
  endfunction

  function automatic logic uop_writes_rd(input uop_t uop);
    return (uop.opcode != OPC_BRANCH) && (uop.opcode != OPC_STORE) && (uop.rd != 5'd0);
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Register busy-bit scoreboard: one bit per architectural register, set on
// issue, cleared on writeback, with x0 hardwired idle.
module issue_scoreboard (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [4:0] set_rd,
  input  logic       clr_en,
  input  logic [4:0] clr_rd,
  input  logic [4:0] rs1_idx,
  input  logic [4:0] rs2_idx,
  input  logic [4:0] rd_idx,
  output logic       rs1_busy,
  output logic       rs2_busy,
  output logic       rd_busy
);

  logic [31:0] busy;
  logic [31:0] busy_next;

  // Clear is applied before set so an issue wins over a same-cycle writeback.
  always_comb begin
    busy_next = busy;
    if (clr_en) busy_next[clr_rd] = 1'b0;
    if (set_en) busy_next[set_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_next;
  end

  assign rs1_busy = busy[rs1_idx];
  assign rs2_busy = busy[rs2_idx];
  assign rd_busy  = busy[rd_idx];

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: circular FIFO of decoded uops whose head issues to
// the ALU or LSU once its operands and destination are free in the scoreboard.
module issue_queue
  import riscv_uop_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_enq_valid,
  input  uop_t                   i_uop,
  input  logic [XLEN-1:0]        i_pc,
  output logic                   o_enq_ready,
  input  logic                   i_flush,
  input  logic                   i_wb_en,
  input  logic [4:0]             i_wb_rd,
  output logic                   o_alu_valid,
  input  logic                   i_alu_ready,
  output logic                   o_lsu_valid,
  input  logic                   i_lsu_ready,
  output uop_t                   o_iss_uop,
  output logic [XLEN-1:0]        o_iss_pc,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int IDXW = $clog2(DEPTH);
  localparam int PTRW = IDXW + 1;

  uop_t            uop_mem [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];

  logic [PTRW-1:0] wr_ptr;
  logic [PTRW-1:0] rd_ptr;
  logic [PTRW-1:0] count;

  logic    full;
  logic    empty;
  logic    enq;
  logic    deq;
  uop_t    head_uop;
  fu_sel_t head_fu;
  logic    head_writes_rd;
  logic    head_ready;
  logic    rs1_busy;
  logic    rs2_busy;
  logic    rd_busy;

  assign full  = (wr_ptr[IDXW-1:0] == rd_ptr[IDXW-1:0]) && (wr_ptr[IDXW] != rd_ptr[IDXW]);
  assign empty = (wr_ptr == rd_ptr);

  assign o_enq_ready = !full;
  assign o_count     = count;
  assign enq         = i_enq_valid && !full && !i_flush;

  // Empty forces the head to zero so stale storage is never visible.
  assign head_uop  = empty ? '0 : uop_mem[rd_ptr[IDXW-1:0]];
  assign o_iss_uop = head_uop;
  assign o_iss_pc  = empty ? '0 : pc_mem[rd_ptr[IDXW-1:0]];

  assign head_fu        = classify_fu(head_uop.opcode);
  assign head_writes_rd = uop_writes_rd(head_uop);

  assign head_ready = !empty
                   && !(head_uop.uses_rs1 && rs1_busy)
                   && !(uop_uses_rs2(head_uop.opcode) && rs2_busy)
                   && !(head_writes_rd && rd_busy);

  assign o_alu_valid = head_ready && !i_flush && (head_fu == FU_ALU);
  assign o_lsu_valid = head_ready && !i_flush && (head_fu == FU_LSU);
  assign deq         = (o_alu_valid && i_alu_ready) || (o_lsu_valid && i_lsu_ready);

  issue_scoreboard u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (deq && head_writes_rd),
    .set_rd   (head_uop.rd),
    .clr_en   (i_wb_en),
    .clr_rd   (i_wb_rd),
    .rs1_idx  (head_uop.rs1),
    .rs2_idx  (head_uop.rs2),
    .rd_idx   (head_uop.rd),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy),
    .rd_busy  (rd_busy)
  );

  // Payload storage carries no reset; the pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (enq) begin
      uop_mem[wr_ptr[IDXW-1:0]] <= i_uop;
      pc_mem[wr_ptr[IDXW-1:0]]  <= i_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (i_flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PTRW'(1);
      if (deq) rd_ptr <= rd_ptr + PTRW'(1);
      count <= count + PTRW'(enq) - PTRW'(deq);
    end
  end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue: directed scenarios plus random traffic,
// all compared every cycle against a queue-and-array reference model.
module tb_issue_queue;
  import riscv_uop_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OP_IMM = 7'b0010011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_STORE  = 7'b0100011;

  logic [6:0] opc_tab [10] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1100011,
                               7'b1101111, 7'b1100111, 7'b0000011, 7'b0100011, 7'b0001111};

  logic            clk;
  logic            rst_n;
  logic            i_enq_valid;
  uop_t            i_uop;
  logic [XLEN-1:0] i_pc;
  logic            o_enq_ready;
  logic            i_flush;
  logic            i_wb_en;
  logic [4:0]      i_wb_rd;
  logic            o_alu_valid;
  logic            i_alu_ready;
  logic            o_lsu_valid;
  logic            i_lsu_ready;
  uop_t            o_iss_uop;
  logic [XLEN-1:0] o_iss_pc;
  logic [2:0]      o_count;

  issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_enq_valid (i_enq_valid),
    .i_uop       (i_uop),
    .i_pc        (i_pc),
    .o_enq_ready (o_enq_ready),
    .i_flush     (i_flush),
    .i_wb_en     (i_wb_en),
    .i_wb_rd     (i_wb_rd),
    .o_alu_valid (o_alu_valid),
    .i_alu_ready (i_alu_ready),
    .o_lsu_valid (o_lsu_valid),
    .i_lsu_ready (i_lsu_ready),
    .o_iss_uop   (o_iss_uop),
    .o_iss_pc    (o_iss_pc),
    .o_count     (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    uop_t            uop;
    logic [XLEN-1:0] pc;
  } entry_t;

  entry_t model_q[$];
  bit     model_busy[32];
  int     num_checks = 0;
  int     num_fails  = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    num_checks++;
    if (got !== exp) begin
      num_fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_is_lsu(input logic [6:0] op);
    return (op == T_LOAD) || (op == T_STORE);
  endfunction

  function automatic bit ref_reads_rs2(input logic [6:0] op);
    return (op == T_OP) || (op == T_BRANCH) || (op == T_STORE);
  endfunction

  function automatic bit ref_writes(input uop_t u);
    return !(u.opcode == T_BRANCH || u.opcode == T_STORE) && (u.rd != 0);
  endfunction

  function automatic uop_t mk(input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2, input logic r1);
    uop_t u;
    u = '0;
    u.opcode   = op;
    u.rd       = rd;
    u.rs1      = rs1;
    u.rs2      = rs2;
    u.uses_rs1 = r1;
    return u;
  endfunction

  // One clock: drive inputs, compare at negedge against the model, advance the model.
  task automatic applyStimulus(input logic enq, input uop_t u, input logic [31:0] pc,
                               input logic alu_rdy, input logic lsu_rdy, input logic wb,
                               input logic [4:0] wbrd, input logic flush);
    entry_t h;
    bit     rdy, exp_alu, exp_lsu, fire, do_enq;
    i_enq_valid = enq;
    i_uop       = u;
    i_pc        = pc;
    i_alu_ready = alu_rdy;
    i_lsu_ready = lsu_rdy;
    i_wb_en     = wb;
    i_wb_rd     = wbrd;
    i_flush     = flush;
    @(negedge clk);
    rdy = 0;
    h.uop = '0;
    h.pc  = '0;
    if (model_q.size() > 0) begin
      h   = model_q[0];
      rdy = !(h.uop.uses_rs1 && model_busy[h.uop.rs1])
         && !(ref_reads_rs2(h.uop.opcode) && model_busy[h.uop.rs2])
         && !(ref_writes(h.uop) && model_busy[h.uop.rd]);
    end
    exp_alu = rdy && !flush && !ref_is_lsu(h.uop.opcode);
    exp_lsu = rdy && !flush && ref_is_lsu(h.uop.opcode);
    checkOutput("enq_ready", 64'(o_enq_ready), 64'(model_q.size() < DEPTH));
    checkOutput("alu_valid", 64'(o_alu_valid), 64'(exp_alu));
    checkOutput("lsu_valid", 64'(o_lsu_valid), 64'(exp_lsu));
    checkOutput("count", 64'(o_count), 64'(model_q.size()));
    checkOutput("iss_uop", 64'(o_iss_uop), 64'(h.uop));
    checkOutput("iss_pc", 64'(o_iss_pc), 64'(h.pc));
    fire   = (exp_alu && alu_rdy) || (exp_lsu && lsu_rdy);
    do_enq = enq && (model_q.size() < DEPTH) && !flush;
    if (wb) model_busy[wbrd] = 0;
    if (fire && ref_writes(h.uop)) model_busy[h.uop.rd] = 1;
    if (flush) model_q.delete();
    else begin
      if (fire) void'(model_q.pop_front());
      if (do_enq) model_q.push_back('{uop: u, pc: pc});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic alu_rdy, input logic lsu_rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, alu_rdy, lsu_rdy, 0, 0, 0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must respond without a clock edge.
  task automatic doReset();
    i_enq_valid = 0;
    i_wb_en     = 0;
    i_flush     = 0;
    #2 rst_n = 0;
    #1;
    checkOutput("rst_enq_ready", 64'(o_enq_ready), 64'd1);
    checkOutput("rst_alu_valid", 64'(o_alu_valid), 64'd0);
    checkOutput("rst_lsu_valid", 64'(o_lsu_valid), 64'd0);
    checkOutput("rst_count", 64'(o_count), 64'd0);
    checkOutput("rst_iss_uop", 64'(o_iss_uop), 64'd0);
    checkOutput("rst_iss_pc", 64'(o_iss_pc), 64'd0);
    model_q.delete();
    for (int i = 0; i < 32; i++) model_busy[i] = 0;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    uop_t ru;
    rst_n = 0;
    i_enq_valid = 0; i_uop = '0; i_pc = '0; i_flush = 0;
    i_wb_en = 0; i_wb_rd = '0; i_alu_ready = 0; i_lsu_ready = 0;
    for (int i = 0; i < 32; i++) model_busy[i] = 0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_enq_ready", 64'(o_enq_ready), 64'd1);
    checkOutput("init_valids", 64'({o_alu_valid, o_lsu_valid}), 64'd0);
    checkOutput("init_count", 64'(o_count), 64'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    $display("[TB] back-to-back independent ALU uops");
    for (int i = 0; i < 4; i++)
      applyStimulus(1, mk(T_OP_IMM, 5'(10 + i), 0, 0, 1), 32'h100 + 32'(4 * i), 1, 1, 0, 0, 0);
    idle(2, 1, 1);
    checkOutput("burst_count_end", 64'(o_count), 64'd0);
    doReset();

    $display("[TB] RAW dependency on x5");
    applyStimulus(1, mk(T_OP, 5, 0, 0, 1), 32'h200, 1, 1, 0, 0, 0);
    applyStimulus(1, mk(T_OP, 6, 5, 5, 1), 32'h204, 1, 1, 0, 0, 0);
    idle(3, 1, 1);
    checkOutput("raw_hold", 64'(o_alu_valid), 64'd0);
    applyStimulus(0, '0, 0, 1, 1, 1, 5, 0);
    checkOutput("raw_release", 64'(o_alu_valid), 64'd1);
    idle(2, 1, 1);
    doReset();

    $display("[TB] fill to DEPTH with ALU stalled");
    for (int i = 0; i < 5; i++)
      applyStimulus(1, mk(T_OP_IMM, 0, 0, 0, 0), 32'h300 + 32'(4 * i), 0, 1, 0, 0, 0);
    checkOutput("full_count", 64'(o_count), 64'd4);
    checkOutput("full_ready", 64'(o_enq_ready), 64'd0);
    applyStimulus(1, mk(T_OP_IMM, 0, 0, 0, 0), 32'h310, 1, 1, 0, 0, 0);
    checkOutput("full_deq_count", 64'(o_count), 64'd3);
    applyStimulus(1, mk(T_OP_IMM, 0, 0, 0, 0), 32'h310, 0, 1, 0, 0, 0);
    checkOutput("refill_count", 64'(o_count), 64'd4);
    idle(5, 1, 1);
    doReset();

    $display("[TB] LSU stall keeps order");
    applyStimulus(1, mk(T_LOAD, 9, 2, 0, 1), 32'h400, 1, 0, 0, 0, 0);
    applyStimulus(1, mk(T_OP, 3, 0, 0, 0), 32'h404, 1, 0, 0, 0, 0);
    idle(2, 1, 0);
    checkOutput("lsu_pc_hold", 64'(o_iss_pc), 64'h400);
    checkOutput("lsu_no_alu", 64'(o_alu_valid), 64'd0);
    idle(3, 1, 1);
    doReset();

    $display("[TB] flush keeps scoreboard");
    applyStimulus(1, mk(T_OP, 7, 0, 0, 0), 32'h500, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus(1, mk(T_OP_IMM, 0, 0, 0, 0), 32'h504 + 32'(4 * i), 0, 1, 0, 0, 0);
    applyStimulus(1, mk(T_OP_IMM, 0, 0, 0, 0), 32'h520, 1, 1, 0, 0, 1);
    checkOutput("flush_count", 64'(o_count), 64'd0);
    applyStimulus(1, mk(T_OP, 8, 7, 0, 1), 32'h530, 1, 1, 0, 0, 0);
    idle(2, 1, 1);
    checkOutput("flush_busy_hold", 64'(o_alu_valid), 64'd0);
    applyStimulus(0, '0, 0, 1, 1, 1, 7, 0);
    idle(2, 1, 1);

    $display("[TB] reset during stall");
    applyStimulus(1, mk(T_OP, 9, 0, 0, 0), 32'h600, 1, 1, 0, 0, 0);
    applyStimulus(1, mk(T_OP_IMM, 0, 0, 0, 0), 32'h604, 0, 1, 0, 0, 0);
    applyStimulus(1, mk(T_OP_IMM, 0, 0, 0, 0), 32'h608, 0, 1, 0, 0, 0);
    doReset();
    applyStimulus(1, mk(T_OP, 10, 9, 9, 1), 32'h610, 1, 1, 0, 0, 0);
    checkOutput("reset_busy_clear", 64'(o_alu_valid), 64'd1);
    idle(2, 1, 1);

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      ru = '0;
      ru.opcode   = opc_tab[$urandom_range(0, 9)];
      ru.rd       = 5'($urandom_range(0, 7));
      ru.rs1      = 5'($urandom_range(0, 7));
      ru.rs2      = 5'($urandom_range(0, 7));
      ru.uses_rs1 = 1'($urandom_range(0, 1));
      ru.funct3   = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) doReset();
      applyStimulus(1'($urandom_range(0, 3) != 0), ru, $urandom(),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 2) == 0), 5'($urandom_range(1, 7)),
                    1'($urandom_range(0, 39) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
